// File: rtl/apb_multi_slave_mem_pkg.sv
// Shared APB types: transfer direction, error/protection codes and slave FSM states.
package apb_global_pkg;

  typedef enum logic {
    NO_ERROR    = 1'b0,
    SLAVE_ERROR = 1'b1
  } slave_error_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  typedef enum logic [2:0] {
    NORMAL_SECURE_DATA         = 3'b000,
    PRIVILEGED_SECURE_DATA     = 3'b001,
    NORMAL_NONSECURE_DATA      = 3'b010,
    PRIVILEGED_NONSECURE_DATA  = 3'b011,
    NORMAL_SECURE_INSTR        = 3'b100,
    PRIVILEGED_SECURE_INSTR    = 3'b101,
    NORMAL_NONSECURE_INSTR     = 3'b110,
    PRIVILEGED_NONSECURE_INSTR = 3'b111
  } protection_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slave_state_e;

  localparam int unsigned PROT_NONSECURE_BIT = 1;

endpackage

// File: rtl/apb_strb_mem.sv
// One slave region: DEPTH x DATA_WIDTH register array, byte-lane writes, synchronous clear.
module apb_strb_mem #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    we,
  input  logic [IDX_WIDTH-1:0]    idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned b = 0; b < DATA_WIDTH/8; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/apb_multi_slave_mem.sv
// APB slave with NO_OF_SLAVES strobe-writable memory regions, wait states and error counting.
// Optional secure-slave check enabled by defining APB_SLAVE_PROT_CHECK_EN.
module apb_multi_slave_mem
  import apb_global_pkg::*;
#(
  parameter int NO_OF_SLAVES       = 2,
  parameter int ADDRESS_WIDTH      = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int SLAVE_MEMORY_DEPTH = 16,
  parameter logic [NO_OF_SLAVES-1:0] SECURE_MASK = '0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [NO_OF_SLAVES-1:0] pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  input  logic [3:0]              wait_cfg,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [15:0]             err_count
);

  localparam int unsigned AL = $clog2(DATA_WIDTH/8);
  localparam int unsigned IW = (SLAVE_MEMORY_DEPTH > 1) ? $clog2(SLAVE_MEMORY_DEPTH) : 1;
  localparam int unsigned SW = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

  apb_slave_state_e          state_q;
  logic [3:0]                cnt_q;
  logic [IW-1:0]             idx_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   strb_q;
  tx_type_e                  dir_q;
  logic [NO_OF_SLAVES-1:0]   sel_q;
  slave_error_e              err_q;

  logic multi_sel, out_of_range, misaligned, prot_fault, setup_err;
  logic unused_prot;

  always_comb begin
    multi_sel    = $countones(pselx) > 1;
    out_of_range = (paddr >> AL) >= ADDRESS_WIDTH'(SLAVE_MEMORY_DEPTH);
    misaligned   = (paddr & ADDRESS_WIDTH'((1 << AL) - 1)) != '0;
`ifdef APB_SLAVE_PROT_CHECK_EN
    prot_fault   = pprot[PROT_NONSECURE_BIT] && ((pselx & SECURE_MASK) != '0);
`else
    prot_fault   = 1'b0;
`endif
    setup_err    = multi_sel || out_of_range || misaligned || prot_fault;
  end

`ifdef APB_SLAVE_PROT_CHECK_EN
  assign unused_prot = ^{pprot[2], pprot[0]};
`else
  assign unused_prot = ^{pprot, SECURE_MASK};
`endif

  // Completion is combinational on penable so a zero-wait transfer finishes in its first ACCESS cycle.
  assign pready  = !preset && (state_q == ACCESS) && (cnt_q == '0) && penable;
  assign pslverr = pready && (err_q == SLAVE_ERROR);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_count <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      dir_q     <= READ;
      sel_q     <= '0;
      err_q     <= NO_ERROR;
    end else begin
      case (state_q)
        IDLE: begin
          if (pselx != '0 && !penable) begin
            idx_q   <= paddr[AL +: IW];
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            dir_q   <= pwrite ? WRITE : READ;
            sel_q   <= pselx;
            cnt_q   <= wait_cfg;
            err_q   <= setup_err ? SLAVE_ERROR : NO_ERROR;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (pready) begin
            state_q <= IDLE;
            if (err_q == SLAVE_ERROR && err_count != '1) err_count <= err_count + 16'd1;
          end else if (pselx == '0) begin
            state_q <= IDLE;
          end else if (penable && cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] rdata [NO_OF_SLAVES];
  logic [SW-1:0]         sel_idx;

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NO_OF_SLAVES; i++)
      if (sel_q[i]) sel_idx = SW'(i);
  end

  for (genvar g = 0; g < NO_OF_SLAVES; g++) begin : g_slave
    logic we;
    assign we = pready && (dir_q == WRITE) && (err_q == NO_ERROR) && sel_q[g];
    apb_strb_mem #(
      .DEPTH      (SLAVE_MEMORY_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (IW)
    ) u_mem (
      .clk   (pclk),
      .clear (preset),
      .we    (we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .wstrb (strb_q),
      .rdata (rdata[g])
    );
  end

  assign prdata = (pready && dir_q == READ && err_q == NO_ERROR) ? rdata[sel_idx] : '0;

endmodule

// File: doc/apb_multi_slave_mem.md
APB_MULTI_SLAVE_MEM -- requirements
Module: apb_multi_slave_mem

Interface
REQ-001 The module SHALL have parameter NO_OF_SLAVES, default 2, the number of slave regions (1..16), each selected by one pselx bit.
REQ-002 The module SHALL have parameter ADDRESS_WIDTH, default 32, the paddr width.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 32, the data width (8/16/32/64).
REQ-004 The module SHALL have parameter SLAVE_MEMORY_DEPTH, default 16, the words per slave region.
REQ-005 The module SHALL have parameter SECURE_MASK, default all-zero, NO_OF_SLAVES bits; bit i=1 marks slave i secure-only.
REQ-006 Port pclk: input, 1, the single clock; all logic on its rising edge.
REQ-007 Port preset: input, 1, reset, synchronous and active-high.
REQ-008 Ports pselx/penable/pwrite: input, NO_OF_SLAVES/1/1, APB select, enable and direction.
REQ-009 Ports paddr/pwdata/pstrb/pprot: input, ADDRESS_WIDTH/DATA_WIDTH/DATA_WIDTH/8/3, APB byte address, write data, byte strobes, protection.
REQ-010 Port wait_cfg: input, 4, wait states to insert, sampled in SETUP.
REQ-011 Ports prdata/pready/pslverr: output, DATA_WIDTH/1/1, APB read data, ready, error.
REQ-012 Port err_count: output, 16, saturating count of completed errored transfers.

Function
REQ-013 The FSM SHALL have states IDLE and ACCESS.
REQ-014 In IDLE, on (pselx!=0 && !penable), the block SHALL latch paddr, pwdata, pstrb, pwrite, pprot and pselx, load wait counter=wait_cfg, compute the error flag, and go to ACCESS.
REQ-015 pready SHALL be 1 exactly when state==ACCESS && counter==0 && penable; in ACCESS with counter!=0 and penable, the counter SHALL decrement each cycle.
REQ-016 With wait_cfg=0, pready SHALL rise in the first ACCESS cycle (zero-wait transfer); with wait_cfg=N, N low-pready ACCESS cycles SHALL precede it.
REQ-017 On the completion cycle (pready=1), the FSM SHALL return to IDLE; a SETUP in the following cycle SHALL be accepted (back-to-back).
REQ-018 The error flag SHALL be set if: pselx has more than one bit set; the word index (paddr >> log2(DATA_WIDTH/8)) >= SLAVE_MEMORY_DEPTH; or the low paddr bits are not word-aligned.
REQ-019 pslverr SHALL equal the error flag during pready=1 and SHALL be 0 otherwise.
REQ-020 A write without error SHALL update only the byte lanes whose pstrb bit is 1, in the completion cycle.
REQ-021 An errored write SHALL leave memory unchanged.
REQ-022 A read SHALL ignore pstrb and drive the addressed word on prdata during pready=1. prdata SHALL be 0 when pready=0 or on error.
REQ-023 If pselx goes to 0 in ACCESS before completion, the transfer SHALL abort with no write and no err_count change, and the FSM SHALL go to IDLE.
REQ-024 err_count SHALL increment on each completion with pslverr=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-025 While preset=1 at a pclk edge: state=IDLE, counter=0, err_count=0, all memory words=0. pready, pslverr and prdata SHALL read 0.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer with no memory write.

Configuration
REQ-027 With APB_SLAVE_PROT_CHECK_EN defined, an access with pprot[1]=1 (non-secure) to a slave whose SECURE_MASK bit is 1 SHALL set the error flag.
REQ-028 Without APB_SLAVE_PROT_CHECK_EN, pprot SHALL be ignored and SECURE_MASK SHALL have no effect.

Structure
REQ-029 The state enum apb_slave_state_e (IDLE, ACCESS) SHALL be added to apb_global_pkg alongside slave_error_e, tx_type_e and protection_type_e, which the module SHALL use.
REQ-030 Each slave region SHALL be one instance of sub-module apb_strb_mem, a SLAVE_MEMORY_DEPTH x DATA_WIDTH byte-lane-writable register array with synchronous clear.

Verification (NO_OF_SLAVES=2, DATA_WIDTH=32, SLAVE_MEMORY_DEPTH=16)
REQ-031 Write pselx=2'b01, paddr=0x8, pwdata=0xDEADBEEF, pstrb=4'hF, wait_cfg=0 -> pready in the first ACCESS cycle, pslverr=0. A later read of 0x8 -> prdata=0xDEADBEEF.
REQ-032 Next, write 0x8 with 0x11223344, pstrb=4'b0101 -> a read of 0x8 returns 0xDE22BE44.
REQ-033 wait_cfg=3 read -> pready low for 3 ACCESS cycles, high in the 4th.
REQ-034 paddr=0x40, then pselx=2'b11, then paddr=0x6 -> pslverr=1 on each, memory unchanged, err_count=3.
REQ-035 wait_cfg=5 write, pselx dropped after 1 ACCESS cycle -> no write, err_count unchanged, next SETUP accepted.
REQ-036 SECURE_MASK=2'b10, pprot=3'b010, write to slave 1 -> pslverr=1 with APB_SLAVE_PROT_CHECK_EN defined; pslverr=0 and data written without it.
